// File: rtl/gray_codec.sv
// rtl/gray_codec.sv - binary<->Gray converter with a one-deep valid/ready output register
// Optional Gray-stream adjacency check enabled by defining GRAY_CODEC_STEP_CHECK_EN.
module gray_codec #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
`ifdef GRAY_CODEC_STEP_CHECK_EN
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             step_err
`else
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_data;
  logic             r_mode;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_conv;

  assign in_ready   = !r_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_valid && out_ready;

  // Gray->binary is a running XOR from the MSB downwards.
  always_comb begin
    logic acc;
    w_b2g = in_data ^ (in_data >> 1);
    w_g2b = '0;
    acc   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ in_data[i];
      w_g2b[i] = acc;
    end
    w_conv = in_mode ? w_g2b : w_b2g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_in_xfer) begin
        r_data  <= w_conv;
        r_mode  <= in_mode;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + CNT_ONE;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_mode  = r_mode;
  assign out_data  = r_data;
  assign xfer_cnt  = r_cnt;

`ifdef GRAY_CODEC_STEP_CHECK_EN
  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_last_gray;
  logic             r_have_last;
  logic             r_step_err;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi;

  // Clearing the lowest set bit leaves a nonzero value only when 2+ bits differ.
  always_comb begin
    w_gray  = in_mode ? in_data : w_b2g;
    w_diff  = w_gray ^ r_last_gray;
    w_multi = (w_diff & (w_diff - W_ONE)) != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gray <= '0;
      r_have_last <= 1'b0;
      r_step_err  <= 1'b0;
    end else if (w_in_xfer) begin
      r_last_gray <= w_gray;
      r_have_last <= 1'b1;
      r_step_err  <= r_have_last && w_multi;
    end
  end

  assign step_err = r_step_err;
`endif

endmodule

// File: doc/gray_codec.md
GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 Parameter WIDTH, default 8, shall set the data word width in bits; legal range is 2 to 32.
REQ-002 Parameter CNT_W, default 16, shall set the width of the transfer counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state shall update on the rising edge.
REQ-004 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 Port in_mode, input, 1 bit: conversion direction; 0 = binary to Gray, 1 = Gray to binary.
REQ-008 Port in_data, input, WIDTH bits: the word to convert.
REQ-009 Port out_valid, output, 1 bit: the converted word is valid.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the word.
REQ-011 Port out_mode, output, 1 bit: the in_mode value that travelled with the word.
REQ-012 Port out_data, output, WIDTH bits: the converted word.
REQ-013 Port xfer_cnt, output, CNT_W bits: count of input transfers accepted.
REQ-014 Port step_err, output, 1 bit: adjacency error flag; present only under GRAY_CODEC_STEP_CHECK_EN.

Function
REQ-015 An input transfer shall occur in a cycle with in_valid=1 and in_ready=1; an output transfer shall occur in a cycle with out_valid=1 and out_ready=1.
REQ-016 in_ready shall equal (!out_valid | out_ready), a combinational pass-through, giving full throughput of one word per cycle.
REQ-017 Binary to Gray shall be G[i] = B[i] ^ B[i+1] for i < WIDTH-1, with G[WIDTH-1] = B[WIDTH-1].
REQ-018 Gray to binary shall be B[i] = XOR of G[WIDTH-1:i], for every i.
REQ-019 The output register shall load the converted word and in_mode on an input transfer; latency shall be exactly 1 cycle from the input transfer to out_valid=1.
REQ-020 out_valid shall set on an input transfer and clear on an output transfer that has no simultaneous input transfer.
REQ-021 When an input transfer and an output transfer happen in the same cycle, out_valid shall stay 1 and the register shall take the new word.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_mode shall hold stable, and in_ready shall be 0.
REQ-023 in_mode may change on every word; each word shall be converted using its own mode.
REQ-024 xfer_cnt shall increment by 1 on each input transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-025 While rst=1 at a clock edge: out_valid=0, out_data=0, out_mode=0, xfer_cnt=0, and step_err=0 if present.
REQ-026 Reset during a stall shall discard the held word; in_ready shall read 1 in the first cycle after reset.
REQ-027 in_valid during the rst=1 cycle shall not be accepted and shall not be counted.

Configuration
REQ-028 With macro GRAY_CODEC_STEP_CHECK_EN defined, the block shall keep the Gray-domain value of the last accepted word: in_data when in_mode=1, the converted output when in_mode=0.
REQ-029 With GRAY_CODEC_STEP_CHECK_EN defined, step_err shall be registered alongside out_data and shall be 1 when the new Gray value differs from the previous one in 2 or more bits.
REQ-030 With GRAY_CODEC_STEP_CHECK_EN defined, a difference of 0 or 1 bits shall give step_err=0, and the first word after reset shall never flag.
REQ-031 Without GRAY_CODEC_STEP_CHECK_EN, the step_err port and its storage shall be absent, and all other behaviour shall be unchanged.

Verification
REQ-032 WIDTH=8, mode 0, in_data=0x2D, out_ready=1 -> next cycle out_valid=1, out_data=0x3B, out_mode=0.
REQ-033 WIDTH=8, mode 1, in_data=0x3B -> out_data=0x2D; sweep all 256 values in both modes, and a bin->gray->bin round trip returns the original value.
REQ-034 Stream 0x00..0x0F back-to-back with out_ready=1 -> one output per cycle and xfer_cnt=16; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, out_data stable, no word lost or duplicated.
REQ-035 rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, xfer_cnt=0, in_ready=1.
REQ-036 CNT_W=4, 17 transfers -> xfer_cnt=1, showing wrap.
REQ-037 With GRAY_CODEC_STEP_CHECK_EN: mode-1 words 0x00, 0x01, 0x03, 0x00 -> step_err sequence 0, 0, 0, 1.
